// File: rtl/dcache_req_scheduler_if.sv
// dcache_req_scheduler_if: snoop/CPU request, grant and cache-controller signals of the scheduler.
// master is the scheduler's view, slave is the requester/controller side.
interface dcache_req_scheduler_if #(
  parameter int NR_PORTS = 3,
  parameter int ADDR_W   = 64
);
  localparam int PW = NR_PORTS > 1 ? $clog2(NR_PORTS) : 1;
  logic                       snoop_valid_i;
  logic [ADDR_W-1:0]          snoop_addr_i;
  logic                       snoop_ready_o;
  logic [NR_PORTS-1:0]        port_req_i;
  logic [NR_PORTS*ADDR_W-1:0] port_addr_i;
  logic [NR_PORTS-1:0]        port_gnt_o;
  logic                       ctrl_valid_o;
  logic                       ctrl_ready_i;
  logic                       ctrl_is_snoop_o;
  logic [PW-1:0]              ctrl_port_o;
  logic [ADDR_W-1:0]          ctrl_addr_o;
  logic                       ctrl_done_i;
  logic                       busy_o;
  modport master (
    input  snoop_valid_i, snoop_addr_i, port_req_i, port_addr_i, ctrl_ready_i, ctrl_done_i,
    output snoop_ready_o, port_gnt_o, ctrl_valid_o, ctrl_is_snoop_o, ctrl_port_o, ctrl_addr_o, busy_o
  );
  modport slave (
    output snoop_valid_i, snoop_addr_i, port_req_i, port_addr_i, ctrl_ready_i, ctrl_done_i,
    input  snoop_ready_o, port_gnt_o, ctrl_valid_o, ctrl_is_snoop_o, ctrl_port_o, ctrl_addr_o, busy_o
  );
endinterface

// File: rtl/dcache_req_scheduler.sv
// dcache_req_scheduler: single-outstanding snoop/CPU scheduler in front of the data-cache controller,
// snoop priority with bounded CPU starvation and round-robin among CPU ports.
module dcache_req_scheduler #(
  parameter int NR_PORTS     = 3,
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  dcache_req_scheduler_if.master bus
);
  localparam int PW = NR_PORTS > 1 ? $clog2(NR_PORTS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;
  state_e            state_q, state_d;
  logic [PW-1:0]     rr_q, port_q, cpu_win, idx;
  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic              is_snoop_q, pend_q, cpu_pend, snoop_win, hs;
  assign cpu_pend  = |bus.port_req_i;
  assign snoop_win = bus.snoop_valid_i && !(cpu_pend && starve_q == SW'(STARVE_LIMIT));
  assign hs        = state_q == ISSUE && bus.ctrl_ready_i;
  // Descending scan so the port closest to rr_q is the one left in cpu_win.
  always_comb begin
    cpu_win = '0;
    idx = '0;
    for (int k = NR_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NR_PORTS);
      if (bus.port_req_i[idx]) cpu_win = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? ((bus.snoop_valid_i || cpu_pend) ? ISSUE : IDLE) :
              state_q == ISSUE ? (bus.ctrl_ready_i ? WAIT_DONE : ISSUE) :
                                 (bus.ctrl_done_i ? IDLE : WAIT_DONE);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      starve_q   <= '0;
      port_q     <= '0;
      addr_q     <= '0;
      is_snoop_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == ISSUE) begin
        is_snoop_q <= snoop_win;
        pend_q     <= cpu_pend;
        port_q     <= snoop_win ? '0 : cpu_win;
        addr_q     <= snoop_win ? bus.snoop_addr_i : bus.port_addr_i[cpu_win*ADDR_W +: ADDR_W];
      end
      if (hs && is_snoop_q)
        starve_q <= !pend_q ? '0 : (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1);
      if (hs && !is_snoop_q) begin
        starve_q <= '0;
        rr_q     <= port_q == PW'(NR_PORTS - 1) ? '0 : port_q + 1'b1;
      end
    end
  end
  assign bus.ctrl_valid_o    = state_q == ISSUE;
  assign bus.busy_o          = state_q != IDLE;
  assign bus.snoop_ready_o   = hs && is_snoop_q;
  assign bus.port_gnt_o      = (hs && !is_snoop_q) ? NR_PORTS'(1) << port_q : '0;
  assign bus.ctrl_is_snoop_o = is_snoop_q;
  assign bus.ctrl_port_o     = port_q;
  assign bus.ctrl_addr_o     = addr_q;
endmodule

// File: tb/tb_dcache_req_scheduler.sv
// tb_dcache_req_scheduler: directed scenarios for the snoop/CPU request scheduler.
module tb_dcache_req_scheduler;
  localparam int NP = 3;
  localparam int AW = 64;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  dcache_req_scheduler_if #(.NR_PORTS(NP), .ADDR_W(AW)) bus ();
  dcache_req_scheduler #(.NR_PORTS(NP), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus.master)
  );
  // Requesters must hold until granted.
  for (genvar i = 0; i < NP; i++) begin : g_proto
    assert property (@(posedge clk) disable iff (!rst_ni)
      bus.port_req_i[i] && !bus.port_gnt_o[i] |=> bus.port_req_i[i])
      else $error("port %0d request dropped before grant", i);
  end
  assert property (@(posedge clk) disable iff (!rst_ni)
    bus.snoop_valid_i && !bus.snoop_ready_o |=> bus.snoop_valid_i)
    else $error("snoop dropped before acceptance");

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.snoop_valid_i = 1'b0;
    bus.snoop_addr_i  = '0;
    bus.port_req_i    = '0;
    bus.port_addr_i   = '0;
    bus.ctrl_ready_i  = 1'b0;
    bus.ctrl_done_i   = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    step();
    step();
    vectors++; if (bus.ctrl_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.ctrl_valid_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    vectors++; if (bus.port_gnt_o !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: got %b want 000", bus.port_gnt_o); end
    vectors++; if (bus.snoop_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_snoop_ready: got %b want 0", bus.snoop_ready_o); end
    vectors++; if (bus.ctrl_addr_o !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.ctrl_addr_o); end
    vectors++; if (bus.ctrl_port_o !== 2'd0 || bus.ctrl_is_snoop_o !== 1'b0) begin miscompares++; $display("FAIL reset_port_snoop: got %0d/%b want 0/0", bus.ctrl_port_o, bus.ctrl_is_snoop_o); end
    vectors++; if (dut.rr_q !== 2'd0 || dut.starve_q !== 3'd0) begin miscompares++; $display("FAIL reset_rr_starve: got %0d/%0d want 0/0", dut.rr_q, dut.starve_q); end
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    bus.port_req_i = 3'b010;
    bus.port_addr_i[1*AW +: AW] = 64'h8000_0040;
    bus.ctrl_ready_i = 1'b1;
    step();
    vectors++; if (bus.ctrl_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus.ctrl_valid_o); end
    vectors++; if (bus.ctrl_port_o !== 2'd1) begin miscompares++; $display("FAIL single_port: got %0d want 1", bus.ctrl_port_o); end
    vectors++; if (bus.ctrl_addr_o !== 64'h8000_0040) begin miscompares++; $display("FAIL single_addr: got %h want 80000040", bus.ctrl_addr_o); end
    vectors++; if (bus.port_gnt_o !== 3'b010 || bus.ctrl_is_snoop_o !== 1'b0) begin miscompares++; $display("FAIL single_gnt: got %b/%b want 010/0", bus.port_gnt_o, bus.ctrl_is_snoop_o); end
    step();
    bus.port_req_i = '0;
    vectors++; if (bus.port_gnt_o !== 3'b000 || bus.ctrl_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_gnt_once: got %b/%b want 000/0", bus.port_gnt_o, bus.ctrl_valid_o); end
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_wait: got %b want 1", bus.busy_o); end
    step();
    bus.ctrl_done_i = 1'b1;
    vectors++; if (bus.busy_o !== 1'b1 || bus.port_gnt_o !== 3'b000) begin miscompares++; $display("FAIL single_still_wait: got %b/%b want 1/000", bus.busy_o, bus.port_gnt_o); end
    step();
    bus.ctrl_done_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_round_robin();
    logic [2:0] g [6];
    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int n = 0;
    do_reset();
    bus.port_req_i   = 3'b111;
    bus.ctrl_ready_i = 1'b1;
    bus.ctrl_done_i  = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (bus.port_gnt_o !== 3'b000) begin g[n] = bus.port_gnt_o; n++; end
    end
    vectors++; if (n != 6) begin miscompares++; $display("FAIL rr_timeout: got %0d grants want 6", n); end
    for (int k = 0; k < n; k++) begin
      vectors++; if (g[k] !== exp_g[k]) begin miscompares++; $display("FAIL rr_order[%0d]: got %b want %b", k, g[k], exp_g[k]); end
    end
    step();
    vectors++; if (dut.rr_q !== 2'd0) begin miscompares++; $display("FAIL rr_wrap: got %0d want 0", dut.rr_q); end
    do_reset();
  endtask

  task automatic test_snoop_starve();
    logic s [6];
    logic [2:0] g [6];
    logic [2:0] st [6];
    logic [63:0] a [6];
    logic exp_s [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_g [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    logic [2:0] exp_st [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [63:0] exp_a [6] = '{64'hA000, 64'hA000, 64'hA000, 64'hA000, 64'h1000, 64'hA000};
    int n = 0;
    bus.snoop_valid_i = 1'b1;
    bus.snoop_addr_i  = 64'hA000;
    bus.port_req_i    = 3'b001;
    bus.port_addr_i[0 +: AW] = 64'h1000;
    bus.ctrl_ready_i  = 1'b1;
    bus.ctrl_done_i   = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (bus.snoop_ready_o || bus.port_gnt_o !== 3'b000) begin
        s[n] = bus.snoop_ready_o; g[n] = bus.port_gnt_o; st[n] = dut.starve_q; a[n] = bus.ctrl_addr_o; n++;
      end
    end
    vectors++; if (n != 6) begin miscompares++; $display("FAIL starve_timeout: got %0d grants want 6", n); end
    for (int k = 0; k < n; k++) begin
      vectors++; if (s[k] !== exp_s[k] || g[k] !== exp_g[k]) begin miscompares++; $display("FAIL starve_grant[%0d]: got snoop=%b gnt=%b want snoop=%b gnt=%b", k, s[k], g[k], exp_s[k], exp_g[k]); end
      vectors++; if (st[k] !== exp_st[k]) begin miscompares++; $display("FAIL starve_count[%0d]: got %0d want %0d", k, st[k], exp_st[k]); end
      vectors++; if (a[k] !== exp_a[k]) begin miscompares++; $display("FAIL starve_addr[%0d]: got %h want %h", k, a[k], exp_a[k]); end
    end
    do_reset();
  endtask

  task automatic test_stall();
    bus.port_req_i = 3'b100;
    bus.port_addr_i[2*AW +: AW] = 64'h1234_5678_9ABC_DEF0;
    step();
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.ctrl_valid_o !== 1'b1 || bus.port_gnt_o !== 3'b000) begin miscompares++; $display("FAIL stall_hold[%0d]: got valid=%b gnt=%b want 1/000", c, bus.ctrl_valid_o, bus.port_gnt_o); end
      vectors++; if (bus.ctrl_addr_o !== 64'h1234_5678_9ABC_DEF0 || bus.ctrl_port_o !== 2'd2) begin miscompares++; $display("FAIL stall_payload[%0d]: got %h/%0d want 123456789abcdef0/2", c, bus.ctrl_addr_o, bus.ctrl_port_o); end
      bus.ctrl_done_i = (c == 1);
      step();
    end
    bus.ctrl_ready_i = 1'b1;
    #1;
    vectors++; if (bus.port_gnt_o !== 3'b100 || bus.ctrl_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_grant: got %b/%b want 100/1", bus.port_gnt_o, bus.ctrl_valid_o); end
    step();
    bus.port_req_i = '0;
    bus.ctrl_ready_i = 1'b0;
    vectors++; if (bus.ctrl_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.ctrl_addr_o !== 64'h1234_5678_9ABC_DEF0) begin miscompares++; $display("FAIL stall_wait: got valid=%b busy=%b addr=%h", bus.ctrl_valid_o, bus.busy_o, bus.ctrl_addr_o); end
    bus.ctrl_done_i = 1'b1;
    step();
    bus.ctrl_done_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.snoop_valid_i = 1'b1;
    bus.snoop_addr_i  = 64'hB0;
    bus.port_req_i    = 3'b100;
    bus.port_addr_i[2*AW +: AW] = 64'hC0;
    bus.ctrl_ready_i  = 1'b1;
    step();
    vectors++; if (bus.snoop_ready_o !== 1'b1 || bus.ctrl_is_snoop_o !== 1'b1) begin miscompares++; $display("FAIL mid_snoop_first: got %b/%b want 1/1", bus.snoop_ready_o, bus.ctrl_is_snoop_o); end
    step();
    bus.snoop_valid_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b1 || dut.starve_q !== 3'd1) begin miscompares++; $display("FAIL mid_wait: got busy=%b starve=%0d want 1/1", bus.busy_o, dut.starve_q); end
    #1 rst_ni = 1'b0;
    #1;
    vectors++; if (bus.busy_o !== 1'b0 || bus.ctrl_valid_o !== 1'b0 || bus.ctrl_is_snoop_o !== 1'b0) begin miscompares++; $display("FAIL mid_async_ctrl: got busy=%b valid=%b snoop=%b want 0", bus.busy_o, bus.ctrl_valid_o, bus.ctrl_is_snoop_o); end
    vectors++; if (bus.ctrl_addr_o !== 64'h0 || bus.ctrl_port_o !== 2'd0 || bus.port_gnt_o !== 3'b000 || bus.snoop_ready_o !== 1'b0) begin miscompares++; $display("FAIL mid_async_out: got addr=%h port=%0d gnt=%b rdy=%b want 0", bus.ctrl_addr_o, bus.ctrl_port_o, bus.port_gnt_o, bus.snoop_ready_o); end
    step();
    rst_ni = 1'b1;
    step();
    vectors++; if (bus.ctrl_valid_o !== 1'b1 || bus.ctrl_port_o !== 2'd2 || bus.ctrl_addr_o !== 64'hC0) begin miscompares++; $display("FAIL mid_reissue: got valid=%b port=%0d addr=%h want 1/2/c0", bus.ctrl_valid_o, bus.ctrl_port_o, bus.ctrl_addr_o); end
    vectors++; if (bus.port_gnt_o !== 3'b100) begin miscompares++; $display("FAIL mid_gnt: got %b want 100", bus.port_gnt_o); end
    vectors++; if (dut.rr_q !== 2'd0 || dut.starve_q !== 3'd0) begin miscompares++; $display("FAIL mid_state: got rr=%0d starve=%0d want 0/0", dut.rr_q, dut.starve_q); end
    step();
    bus.port_req_i  = '0;
    bus.ctrl_done_i = 1'b1;
    step();
    bus.ctrl_done_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b want 0", bus.busy_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_snoop_starve();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
